fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001: Parameter WAIT_LIMIT, default 15: maximum cycles spent in MEM_REQ before a fault; legal range 1..255.
REQ-002: CLOCK  in  1  single clock; all state changes on its rising edge.
REQ-003: RESET  in  1  asynchronous reset, active-low.
REQ-004: RUN  in  1  request to fetch instructions continuously; HALT  in  1  stop after the current instruction.
REQ-005: MEM_READY  in  1  memory has read data available; EXEC_DONE  in  1  execute stage finished the current instruction.
REQ-006: PC_EN, PC_RW, PC_COUNT  out  1 each  program-counter register bus enable, read/write (1 = drive bus), increment.
REQ-007: MAR_EN, MAR_RW  out  1 each  memory-address register bus enable and read/write.
REQ-008: IR_EN, IR_RW  out  1 each  instruction register bus enable and read/write.
REQ-009: MEM_RD  out  1  memory read request; MEM_OE  out  1  memory drives the data bus this cycle.
REQ-010: FETCH_DONE  out  1  instruction valid in IR, handed to execute; FAULT  out  1  sticky memory-timeout flag.
REQ-011: STATE  out  3  current state encoding; FETCH_CNT  out  16  completed-fetch count.

Function
REQ-012: The block SHALL be a Moore FSM; every output SHALL be decoded from the state register and counters only, never combinationally from inputs.
REQ-013: States and encodings SHALL be IDLE=0, PC_DRV=1, MAR_LD=2, MEM_REQ=3, IR_LD=4, EXEC=5, FAULT=7.
REQ-014: IDLE: all strobes low; goes to PC_DRV when RUN=1 and HALT=0; otherwise stays in IDLE.
REQ-015: PC_DRV: PC_EN=1, PC_RW=1 (PC register drives the bus from the next edge); always goes to MAR_LD.
REQ-016: MAR_LD: MAR_EN=1, MAR_RW=0 (MAR captures the bus); PC_EN=0, PC_RW=1, PC_COUNT=1 (PC increments); always goes to MEM_REQ.
REQ-017: MEM_REQ: MEM_RD=1; wait counter cleared on entry; MEM_READY=1 goes to IR_LD.
REQ-018: MEM_REQ wait rule: MEM_READY is accepted in the k-th MEM_REQ cycle for k=1..WAIT_LIMIT; if MEM_READY=0 in cycle k=WAIT_LIMIT, the state goes to FAULT.
REQ-019: IR_LD: MEM_OE=1, IR_EN=1, IR_RW=0; FETCH_CNT increments by 1 modulo 2^16 (0xFFFF wraps to 0x0000); always goes to EXEC.
REQ-020: EXEC: FETCH_DONE=1 held until EXEC_DONE=1.
REQ-021: On EXEC_DONE=1 in EXEC, the state goes to PC_DRV if RUN=1 and HALT=0, else to IDLE.
REQ-022: FAULT: FAULT=1, all strobes low; FAULT is terminal and is left only by reset.
REQ-023: HALT and RUN SHALL be sampled only in IDLE and on exit from EXEC; a fetch in progress always completes through EXEC.
REQ-024: In any cycle at most one bus source SHALL be enabled: PC with PC_RW=1, or MEM_OE; the PC SHALL never be enabled with PC_RW=0.
REQ-025: In a wait-free fetch, IDLE to FETCH_DONE high SHALL take exactly 5 cycles (PC_DRV, MAR_LD, MEM_REQ, IR_LD, EXEC).
REQ-026: STATE encodings 6 and unused SHALL recover to IDLE on the next edge with all strobes low.

Reset
REQ-027: While RESET=0: state is IDLE; all strobes, FETCH_DONE and FAULT are 0; FETCH_CNT and the wait counter are 0. This takes effect immediately, without waiting for a clock edge.
REQ-028: Reset asserted mid-fetch (any state) SHALL abandon the fetch with no further strobes.
REQ-029: After release, the first state change SHALL occur on the first rising edge on which RESET=1.

Verification
REQ-030: Basic fetch: RESET release, then RUN=1, MEM_READY=1 -> STATE 1,2,3,4,5 on consecutive cycles; FETCH_DONE=1 in cycle 5; FETCH_CNT=1.
REQ-031: Wait states: MEM_READY rises in the 3rd MEM_REQ cycle (WAIT_LIMIT=15) -> MEM_RD high for 3 cycles, then IR_LD; no FAULT.
REQ-032: Timeout: MEM_READY held 0 with WAIT_LIMIT=4 -> 4 MEM_REQ cycles, then STATE=7 and FAULT=1; FAULT stays 1 with RUN toggled until RESET=0 clears it.
REQ-033: Continuous run/halt: RUN=1 and EXEC_DONE pulsed each EXEC for 3 fetches, with HALT=1 during the 3rd -> 3rd EXEC exits to IDLE; FETCH_CNT=3.
REQ-034: Wrap and reset: FETCH_CNT forced to 0xFFFF, one fetch -> 0x0000; RESET=0 asserted in MEM_REQ -> outputs 0 immediately, STATE=0.
REQ-035: Bus exclusivity assertion checked every cycle in all scenarios: never (PC_EN and PC_RW) and MEM_OE together.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// Handshake and bus-strobe bundle between the fetch sequencer and the datapath/memory side.
// The sequencer uses the master modport. The surrounding datapath or a testbench uses the slave modport.
interface fetch_sequencer_if;
  logic        RUN;
  logic        HALT;
  logic        MEM_READY;
  logic        EXEC_DONE;
  logic        PC_EN;
  logic        PC_RW;
  logic        PC_COUNT;
  logic        MAR_EN;
  logic        MAR_RW;
  logic        IR_EN;
  logic        IR_RW;
  logic        MEM_RD;
  logic        MEM_OE;
  logic        FETCH_DONE;
  logic        FAULT;
  logic [2:0]  STATE;
  logic [15:0] FETCH_CNT;

  modport master (
    input  RUN, HALT, MEM_READY, EXEC_DONE,
    output PC_EN, PC_RW, PC_COUNT, MAR_EN, MAR_RW, IR_EN, IR_RW,
           MEM_RD, MEM_OE, FETCH_DONE, FAULT, STATE, FETCH_CNT
  );

  modport slave (
    output RUN, HALT, MEM_READY, EXEC_DONE,
    input  PC_EN, PC_RW, PC_COUNT, MAR_EN, MAR_RW, IR_EN, IR_RW,
           MEM_RD, MEM_OE, FETCH_DONE, FAULT, STATE, FETCH_CNT
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Moore FSM that sequences instruction fetch: PC onto the bus, MAR load, memory read with timeout,
// IR load, then hand-off to execute. All outputs decode from the state register and the counters.
module fetch_sequencer #(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input logic          CLOCK,
  input logic          RESET,
  fetch_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PC_DRV  = 3'd1,
    ST_MAR_LD  = 3'd2,
    ST_MEM_REQ = 3'd3,
    ST_IR_LD   = 3'd4,
    ST_EXEC    = 3'd5,
    ST_FAULT   = 3'd7
  } state_t;

  // Value of the wait counter in the last permitted MEM_REQ cycle.
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  wait_cnt;
  logic [7:0]  wait_cnt_nxt;
  logic [15:0] fetch_cnt;
  logic [15:0] fetch_cnt_nxt;

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      fetch_cnt <= '0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      fetch_cnt <= fetch_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    wait_cnt_nxt  = wait_cnt;
    fetch_cnt_nxt = fetch_cnt;
    case (state)
      ST_IDLE: begin
        if (bus.RUN && !bus.HALT) state_nxt = ST_PC_DRV;
      end
      ST_PC_DRV: begin
        state_nxt = ST_MAR_LD;
      end
      ST_MAR_LD: begin
        state_nxt    = ST_MEM_REQ;
        wait_cnt_nxt = '0;
      end
      ST_MEM_REQ: begin
        if (bus.MEM_READY) begin
          state_nxt = ST_IR_LD;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt = ST_FAULT;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end
      ST_IR_LD: begin
        state_nxt     = ST_EXEC;
        fetch_cnt_nxt = fetch_cnt + 16'd1;
      end
      ST_EXEC: begin
        if (bus.EXEC_DONE) begin
          state_nxt = (bus.RUN && !bus.HALT) ? ST_PC_DRV : ST_IDLE;
        end
      end
      ST_FAULT: begin
        state_nxt = ST_FAULT;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output decode depends only on the state register. Unused encodings leave every strobe low.
  always_comb begin
    bus.PC_EN      = 1'b0;
    bus.PC_RW      = 1'b0;
    bus.PC_COUNT   = 1'b0;
    bus.MAR_EN     = 1'b0;
    bus.MAR_RW     = 1'b0;
    bus.IR_EN      = 1'b0;
    bus.IR_RW      = 1'b0;
    bus.MEM_RD     = 1'b0;
    bus.MEM_OE     = 1'b0;
    bus.FETCH_DONE = 1'b0;
    bus.FAULT      = 1'b0;
    case (state)
      ST_PC_DRV: begin
        bus.PC_EN = 1'b1;
        bus.PC_RW = 1'b1;
      end
      ST_MAR_LD: begin
        bus.MAR_EN   = 1'b1;
        bus.PC_RW    = 1'b1;
        bus.PC_COUNT = 1'b1;
      end
      ST_MEM_REQ: begin
        bus.MEM_RD = 1'b1;
      end
      ST_IR_LD: begin
        bus.MEM_OE = 1'b1;
        bus.IR_EN  = 1'b1;
      end
      ST_EXEC: begin
        bus.FETCH_DONE = 1'b1;
      end
      ST_FAULT: begin
        bus.FAULT = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.STATE     = state;
  assign bus.FETCH_CNT = fetch_cnt;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a directed vector table, hand-written corner sequences and a randomized
// run compared against a fetch-progress reference model. Two instances cover WAIT_LIMIT of 15 and 4.
module tb_fetch_sequencer;

  logic CLOCK = 1'b0;
  logic RESET = 1'b0;
  always #5 CLOCK = ~CLOCK;

  fetch_sequencer_if ifa();
  fetch_sequencer_if ifb();

  fetch_sequencer #(.WAIT_LIMIT(15)) dut  (.CLOCK(CLOCK), .RESET(RESET), .bus(ifa.master));
  fetch_sequencer #(.WAIT_LIMIT(4))  dut4 (.CLOCK(CLOCK), .RESET(RESET), .bus(ifb.master));

  int vectors     = 0;
  int miscompares = 0;

  // Strobe order: PC_EN PC_RW PC_COUNT MAR_EN MAR_RW IR_EN IR_RW MEM_RD MEM_OE FETCH_DONE FAULT
  logic [10:0] strb_a, strb_b;
  assign strb_a = {ifa.PC_EN, ifa.PC_RW, ifa.PC_COUNT, ifa.MAR_EN, ifa.MAR_RW, ifa.IR_EN,
                   ifa.IR_RW, ifa.MEM_RD, ifa.MEM_OE, ifa.FETCH_DONE, ifa.FAULT};
  assign strb_b = {ifb.PC_EN, ifb.PC_RW, ifb.PC_COUNT, ifb.MAR_EN, ifb.MAR_RW, ifb.IR_EN,
                   ifb.IR_RW, ifb.MEM_RD, ifb.MEM_OE, ifb.FETCH_DONE, ifb.FAULT};

  function automatic logic [10:0] sb_of(input logic [2:0] s);
    case (s)
      3'd1:    return 11'b110_00_00_0_0_0_0;
      3'd2:    return 11'b011_10_00_0_0_0_0;
      3'd3:    return 11'b000_00_00_1_0_0_0;
      3'd4:    return 11'b000_00_10_0_1_0_0;
      3'd5:    return 11'b000_00_00_0_0_1_0;
      3'd7:    return 11'b000_00_00_0_0_0_1;
      default: return 11'b0;
    endcase
  endfunction

  task automatic check(input string name, input int which, input logic [2:0] es, input logic [15:0] ec);
    logic [2:0]  s;
    logic [10:0] b;
    logic [15:0] c;
    if (which == 0) begin s = ifa.STATE; b = strb_a; c = ifa.FETCH_CNT; end
    else            begin s = ifb.STATE; b = strb_b; c = ifb.FETCH_CNT; end
    vectors++;
    if (s !== es || b !== sb_of(es) || c !== ec) begin
      miscompares++;
      $display("FAIL %s: got state=%0d strobes=%b cnt=%h, expected state=%0d strobes=%b cnt=%h",
               name, s, b, c, es, sb_of(es), ec);
    end
  endtask

  task automatic drive(input logic rst, input logic run, input logic halt, input logic rdy, input logic xd);
    RESET = rst;
    ifa.RUN = run; ifa.HALT = halt; ifa.MEM_READY = rdy; ifa.EXEC_DONE = xd;
    ifb.RUN = run; ifb.HALT = halt; ifb.MEM_READY = rdy; ifb.EXEC_DONE = xd;
  endtask

  // Bus exclusivity in every cycle, for both instances.
  always @(negedge CLOCK) begin
    vectors++;
    if ((ifa.PC_EN && ifa.PC_RW && ifa.MEM_OE) || (ifa.PC_EN && !ifa.PC_RW)) begin
      miscompares++;
      $display("FAIL bus_excl_a: pc_en=%b pc_rw=%b mem_oe=%b, required single source", ifa.PC_EN, ifa.PC_RW, ifa.MEM_OE);
    end
    vectors++;
    if ((ifb.PC_EN && ifb.PC_RW && ifb.MEM_OE) || (ifb.PC_EN && !ifb.PC_RW)) begin
      miscompares++;
      $display("FAIL bus_excl_b: pc_en=%b pc_rw=%b mem_oe=%b, required single source", ifb.PC_EN, ifb.PC_RW, ifb.MEM_OE);
    end
  end

  // Reference model: tracks whether a fetch is in progress, which step it is on, and how long memory has stalled.
  typedef struct {
    bit          faulted;
    bit          busy;
    int          step;
    int          waited;
    logic [15:0] fetches;
  } mdl_t;

  function automatic mdl_t mstep(input mdl_t m, input int limit, input logic rst, input logic run,
                                 input logic halt, input logic rdy, input logic xd);
    mdl_t n = m;
    if (!rst) begin
      n = '{1'b0, 1'b0, 0, 0, 16'd0};
      return n;
    end
    if (m.faulted) return n;
    if (!m.busy) begin
      if (run && !halt) begin n.busy = 1'b1; n.step = 0; end
      return n;
    end
    case (m.step)
      0: n.step = 1;
      1: begin n.step = 2; n.waited = 0; end
      2: begin
        if (rdy) n.step = 3;
        else begin
          n.waited = m.waited + 1;
          if (n.waited >= limit) begin n.busy = 1'b0; n.faulted = 1'b1; end
        end
      end
      3: begin n.step = 4; n.fetches = m.fetches + 16'd1; end
      default: begin
        if (xd) begin
          if (run && !halt) n.step = 0;
          else n.busy = 1'b0;
        end
      end
    endcase
    return n;
  endfunction

  function automatic logic [2:0] mstate(input mdl_t m);
    if (m.faulted) return 3'd7;
    if (m.busy) return 3'(m.step + 1);
    return 3'd0;
  endfunction

  typedef struct {
    logic        rst, run, halt, rdy, xd;
    logic [2:0]  st;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl [23];

  initial begin
    mdl_t ma, mb;
    int   memreq_cycles;
    int   rdy_pct;
    logic r_rst, r_run, r_halt, r_rdy, r_xd;

    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    //            rst  run  halt rdy  xd    state cnt
    tbl[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 3'd0, 16'd0};
    tbl[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 3'd0, 16'd0};
    tbl[2]  = '{1'b1,1'b1,1'b1,1'b0,1'b0, 3'd0, 16'd0};
    tbl[3]  = '{1'b1,1'b1,1'b0,1'b1,1'b0, 3'd1, 16'd0};
    tbl[4]  = '{1'b1,1'b1,1'b0,1'b1,1'b0, 3'd2, 16'd0};
    tbl[5]  = '{1'b1,1'b1,1'b0,1'b1,1'b0, 3'd3, 16'd0};
    tbl[6]  = '{1'b1,1'b1,1'b0,1'b1,1'b0, 3'd4, 16'd0};
    tbl[7]  = '{1'b1,1'b1,1'b0,1'b1,1'b0, 3'd5, 16'd1};
    tbl[8]  = '{1'b1,1'b1,1'b0,1'b1,1'b0, 3'd5, 16'd1};
    tbl[9]  = '{1'b1,1'b1,1'b0,1'b0,1'b1, 3'd1, 16'd1};
    tbl[10] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 3'd2, 16'd1};
    tbl[11] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 3'd3, 16'd1};
    tbl[12] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 3'd3, 16'd1};
    tbl[13] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 3'd3, 16'd1};
    tbl[14] = '{1'b1,1'b0,1'b0,1'b1,1'b0, 3'd4, 16'd1};
    tbl[15] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 3'd5, 16'd2};
    tbl[16] = '{1'b1,1'b1,1'b0,1'b0,1'b1, 3'd1, 16'd2};
    tbl[17] = '{1'b1,1'b1,1'b1,1'b0,1'b0, 3'd2, 16'd2};
    tbl[18] = '{1'b1,1'b1,1'b1,1'b1,1'b0, 3'd3, 16'd2};
    tbl[19] = '{1'b1,1'b1,1'b1,1'b1,1'b0, 3'd4, 16'd2};
    tbl[20] = '{1'b1,1'b1,1'b1,1'b0,1'b0, 3'd5, 16'd3};
    tbl[21] = '{1'b1,1'b1,1'b1,1'b0,1'b1, 3'd0, 16'd3};
    tbl[22] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 3'd0, 16'd3};

    #1 check("reset_state", 0, 3'd0, 16'd0);

    for (int i = 0; i < 23; i++) begin
      @(negedge CLOCK);
      drive(tbl[i].rst, tbl[i].run, tbl[i].halt, tbl[i].rdy, tbl[i].xd);
      @(posedge CLOCK); #1;
      check($sformatf("table[%0d]", i), 0, tbl[i].st, tbl[i].cnt);
    end

    // Counter wrap: preload 0xFFFF while idle, then one wait-free fetch.
    @(negedge CLOCK);
    force dut.fetch_cnt = 16'hFFFF;
    @(negedge CLOCK);
    release dut.fetch_cnt;
    #1 check("preload", 0, 3'd0, 16'hFFFF);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (5) @(posedge CLOCK);
    #1 check("wrap", 0, 3'd5, 16'h0000);

    // Reset asserted mid-cycle while stalled in MEM_REQ takes effect without a clock edge.
    @(negedge CLOCK);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (3) @(posedge CLOCK);
    #1 check("memreq_before_reset", 0, 3'd3, 16'h0000);
    #1 RESET = 1'b0;
    #1 check("async_reset", 0, 3'd0, 16'h0000);
    @(negedge CLOCK);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge CLOCK); #1;
    check("first_edge_after_release", 0, 3'd1, 16'h0000);

    // Timeout with WAIT_LIMIT=4: count MEM_REQ cycles until the fault state.
    memreq_cycles = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge CLOCK); #1;
      if (ifb.STATE == 3'd3) memreq_cycles++;
      if (ifb.STATE == 3'd7) break;
    end
    vectors++;
    if (memreq_cycles != 4) begin
      miscompares++;
      $display("FAIL timeout_wait_cycles: got %0d MEM_REQ cycles, expected 4", memreq_cycles);
    end
    check("timeout_fault", 1, 3'd7, 16'h0000);
    for (int c = 0; c < 6; c++) begin
      @(negedge CLOCK);
      drive(1'b1, c[0], 1'b0, 1'b1, 1'b1);
      @(posedge CLOCK); #1;
      check("fault_sticky", 1, 3'd7, 16'h0000);
    end
    #1 RESET = 1'b0;
    #1 check("fault_cleared", 1, 3'd0, 16'h0000);

    // Randomized run against the reference model, both instances.
    @(negedge CLOCK);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    ma = '{1'b0, 1'b0, 0, 0, 16'd0};
    mb = '{1'b0, 1'b0, 0, 0, 16'd0};
    rdy_pct = 35;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge CLOCK);
      check("random_a", 0, mstate(ma), ma.fetches);
      check("random_b", 1, mstate(mb), mb.fetches);
      if (cyc % 250 == 0) begin
        case ($urandom_range(0, 2))
          0:       rdy_pct = 5;
          1:       rdy_pct = 35;
          default: rdy_pct = 85;
        endcase
      end
      r_rst  = ($urandom_range(0, 59) != 0);
      r_run  = ($urandom_range(0, 3) != 0);
      r_halt = ($urandom_range(0, 4) == 0);
      r_rdy  = ($urandom_range(0, 99) < rdy_pct);
      r_xd   = $urandom_range(0, 1) == 1;
      drive(r_rst, r_run, r_halt, r_rdy, r_xd);
      ma = mstep(ma, 15, r_rst, r_run, r_halt, r_rdy, r_xd);
      mb = mstep(mb, 4,  r_rst, r_run, r_halt, r_rdy, r_xd);
    end

    @(negedge CLOCK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
